// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: one-at-a-time instruction sequencer driving the register file and ALU.
// Latency: accept at cycle 0, register write/done at cycle 4 (NOP/illegal at cycle 2); next accept at cycle 5.
// Backpressure: instr_ready only in IDLE; the source holds instr_valid/instr until it is accepted.
module alu_issue_sequencer #(
  parameter logic [3:0] FUNC_ADD = 4'b0000,
  parameter int         REG_AW   = 4,
  parameter int         DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [19:0]       instr,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [3:0]        alu_op,
  output logic [3:0]        func_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB} state_t;

  state_t      state;
  logic [19:0] ir;
  // Decode results carried from DECODE to EXEC/WB.
  logic        is_rtype;
  logic        has_write;
  logic        is_bad;

  logic [3:0] opcode, rd, rs, rt, imm;
  assign opcode = ir[19:16];
  assign rd     = ir[15:12];
  assign rs     = ir[11:8];
  assign rt     = ir[7:4];
  assign imm    = ir[3:0];

  // Handshake and busy come straight from the state so IDLE accepts with no extra cycle.
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Main sequencer: state plus every registered output. Pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ir         <= '0;
      is_rtype   <= 1'b0;
      has_write  <= 1'b0;
      is_bad     <= 1'b0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      alu_op     <= '0;
      func_code  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (opcode)
            4'b1111: begin
              alu_op    <= 4'b1111;
              func_code <= imm;
              is_rtype  <= 1'b1;
              has_write <= 1'b1;
              is_bad    <= 1'b0;
              state     <= READ;
            end
            4'b0001: begin
              alu_op    <= 4'b0000;
              func_code <= FUNC_ADD;
              is_rtype  <= 1'b0;
              has_write <= 1'b1;
              is_bad    <= 1'b0;
              state     <= READ;
            end
            4'b0000: begin
              has_write <= 1'b0;
              is_bad    <= 1'b0;
              state     <= WB;
            end
            default: begin
              // Illegal opcodes go through WB too, so the flag lands on the same cycle a NOP retires.
              has_write <= 1'b0;
              is_bad    <= 1'b1;
              state     <= WB;
            end
          endcase
        end
        READ: begin
          rf_raddr_a <= rs;
          rf_raddr_b <= rt;
          state      <= EXEC;
        end
        EXEC: begin
          alu_a <= rf_rdata_a;
          alu_b <= is_rtype ? rf_rdata_b : {{(DATA_W-4){1'b0}}, imm};
          state <= WB;
        end
        WB: begin
          if (has_write) begin
            rf_wdata <= alu_result;
            rf_waddr <= rd;
          end
          rf_we   <= has_write && (rd != 4'd0);
          done    <= !is_bad;
          illegal <= is_bad;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a register-file array and an adding ALU model.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Each scenario task does its own checks; totals are reported in one summary line.
module tb_alu_issue_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [19:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic [3:0]  alu_op, func_code;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy, done, illegal;

  logic [15:0] rf_mem [16];
  int errors;
  int checks;

  alu_issue_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_op(alu_op), .func_code(func_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rdata_a = rf_mem[rf_raddr_a];
  assign rf_rdata_b = rf_mem[rf_raddr_b];
  assign alu_result = alu_a + alu_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word; returns just after the accepting edge (cycle 0).
  task automatic issue(input logic [19:0] w);
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 20'h0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (alu_op !== 4'h0 || func_code !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0 ||
        rf_waddr !== 4'h0 || rf_wdata !== 16'h0 || rf_raddr_a !== 4'h0 || rf_raddr_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs op=%h fc=%h a=%h b=%h wa=%h wd=%h ra=%h rb=%h required all zero",
               alu_op, func_code, alu_a, alu_b, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (instr_ready !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d ready=%b busy=%b we=%b done=%b ill=%b required 1 0 0 0 0",
                 i, instr_ready, busy, rf_we, done, illegal);
      end
    end
  endtask

  task automatic test_rtype();
    rf_mem[1] = 16'h0007;
    rf_mem[2] = 16'h0002;
    issue(20'hF3125);
    checks++;
    if (instr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rtype_busy ready=%b busy=%b required 0 1", instr_ready, busy);
    end
    step(); // cycle 1
    checks++;
    if (alu_op !== 4'hF || func_code !== 4'h5) begin
      errors++;
      $display("FAIL rtype_decode op=%h fc=%h required f 5", alu_op, func_code);
    end
    step(); // cycle 2
    checks++;
    if (rf_raddr_a !== 4'h1 || rf_raddr_b !== 4'h2) begin
      errors++;
      $display("FAIL rtype_raddr a=%h b=%h required 1 2", rf_raddr_a, rf_raddr_b);
    end
    step(); // cycle 3
    checks++;
    if (alu_a !== 16'h0007 || alu_b !== 16'h0002 || rf_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rtype_exec a=%h b=%h we=%b done=%b required 0007 0002 0 0", alu_a, alu_b, rf_we, done);
    end
    step(); // cycle 4
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'h3 || rf_wdata !== 16'h0009 || done !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rtype_wb we=%b wa=%h wd=%h done=%b ill=%b required 1 3 0009 1 0",
               rf_we, rf_waddr, rf_wdata, done, illegal);
    end
    checks++;
    if (instr_ready !== 1'b1 || alu_op !== 4'hF || func_code !== 4'h5) begin
      errors++;
      $display("FAIL rtype_ready ready=%b op=%h fc=%h required 1 f 5", instr_ready, alu_op, func_code);
    end
    step();
    checks++;
    if (rf_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rtype_pulse we=%b done=%b required 0 0", rf_we, done);
    end
  endtask

  task automatic test_addi();
    rf_mem[2] = 16'h0010;
    rf_mem[0] = 16'hBEEF;
    issue(20'h1420A);
    step();
    checks++;
    if (alu_op !== 4'h0 || func_code !== 4'h0) begin
      errors++;
      $display("FAIL addi_decode op=%h fc=%h required 0 0", alu_op, func_code);
    end
    step();
    step();
    checks++;
    if (alu_a !== 16'h0010 || alu_b !== 16'h000A) begin
      errors++;
      $display("FAIL addi_exec a=%h b=%h required 0010 000a", alu_a, alu_b);
    end
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'h4 || rf_wdata !== 16'h001A || done !== 1'b1) begin
      errors++;
      $display("FAIL addi_wb we=%b wa=%h wd=%h done=%b required 1 4 001a 1", rf_we, rf_waddr, rf_wdata, done);
    end
    step();
  endtask

  task automatic test_r0_and_nop();
    rf_mem[1] = 16'h0007;
    rf_mem[2] = 16'h0002;
    issue(20'hF0120);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (rf_we !== 1'b0 || done !== (i == 4)) begin
        errors++;
        $display("FAIL r0_write cyc=%0d we=%b done=%b required 0 %0d", i, rf_we, done, (i == 4));
      end
    end
    step();
    issue(20'h00000);
    step();
    checks++;
    if (done !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL nop_cyc1 done=%b we=%b required 0 0", done, rf_we);
    end
    step();
    checks++;
    if (done !== 1'b1 || rf_we !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL nop_retire done=%b we=%b ill=%b ready=%b required 1 0 0 1", done, rf_we, illegal, instr_ready);
    end
    step();
  endtask

  task automatic test_illegal();
    issue(20'h73125);
    step();
    checks++;
    if (illegal !== 1'b0 || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_cyc1 ill=%b ready=%b required 0 0", illegal, instr_ready);
    end
    step();
    checks++;
    if (illegal !== 1'b1 || done !== 1'b0 || rf_we !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag ill=%b done=%b we=%b ready=%b required 1 0 0 1", illegal, done, rf_we, instr_ready);
    end
    step();
    checks++;
    if (illegal !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse ill=%b done=%b required 0 0", illegal, done);
    end
  endtask

  task automatic test_reset_busy();
    rf_mem[1] = 16'h0007;
    rf_mem[2] = 16'h0002;
    issue(20'hF3125);
    step();
    step(); // now in EXEC
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || instr_ready !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0 || alu_op !== 4'h0) begin
      errors++;
      $display("FAIL reset_busy busy=%b ready=%b we=%b done=%b op=%h required 0 1 0 0 0",
               busy, instr_ready, rf_we, done, alu_op);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_write cyc=%0d we=%b done=%b busy=%b required 0 0 0", i, rf_we, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    rf_mem[1] = 16'h0007;
    rf_mem[2] = 16'h0002;
    issue(20'hF5120);
    // Second word offered immediately and held; it must wait for IDLE.
    instr = 20'h16103;
    instr_valid = 1'b1;
    step();
    step();
    step();
    step(); // cycle 4 of first
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'h5 || rf_wdata !== 16'h0009 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first we=%b wa=%h wd=%h ready=%b required 1 5 0009 1", rf_we, rf_waddr, rf_wdata, instr_ready);
    end
    step(); // accepts second
    instr_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b we=%b required 1 0", busy, rf_we);
    end
    step();
    step();
    step();
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'h6 || rf_wdata !== 16'h000A || done !== 1'b1 || func_code !== 4'h0) begin
      errors++;
      $display("FAIL b2b_second we=%b wa=%h wd=%h done=%b fc=%h required 1 6 000a 1 0",
               rf_we, rf_waddr, rf_wdata, done, func_code);
    end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0;
    test_reset();
    test_rtype();
    test_addi();
    test_r0_and_nop();
    test_illegal();
    test_reset_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
